// File: rtl/shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shift_cmd_fifo
// Description : Four-entry show-ahead command FIFO feeding the 8-bit barrel
//               shifter. Each entry holds {data, amount, direction}; the head
//               entry drives the shifter inputs behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] In_d,
  input  logic [2:0] n_d,
  input  logic       Lr_d,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] In,
  output logic [2:0] n,
  output logic       Lr,
  output logic [2:0] count,
  output logic       overflow
);

  localparam int         c_PTR_W   = $clog2(DEPTH);
  localparam int         c_ENTRY_W = 12;
  localparam logic [2:0] c_FULL    = 3'(DEPTH);

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [2:0]           r_count;
  logic                 r_overflow;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [c_ENTRY_W-1:0] w_head;

  // Handshake qualification: a full FIFO refuses pushes even if it pops this cycle.
  always_comb begin
    w_full   = (r_count == c_FULL);
    w_empty  = (r_count == 3'd0);
    w_push   = in_valid && !w_full;
    w_pop    = out_ready && !w_empty;
    w_head   = r_mem[r_rd_ptr];
  end

  // Entry storage: cleared on reset so the head outputs read zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {In_d, n_d, Lr_d};
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: any push attempt while full is recorded until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Output drive: head entry is presented show-ahead from registered storage.
  always_comb begin
    in_ready  = !w_full;
    out_valid = !w_empty;
    In        = w_head[11:4];
    n         = w_head[3:1];
    Lr        = w_head[0];
    count     = r_count;
    overflow  = r_overflow;
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_cmd_fifo
// Description : Self-checking bench for shift_cmd_fifo using a queue-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_cmd_fifo;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] In_d;
  logic [2:0] n_d;
  logic       Lr_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] In;
  logic [2:0] n;
  logic       Lr;
  logic [2:0] count;
  logic       overflow;

  int vectors;
  int miscompares;

  // Reference model: an ordered list of commands plus the sticky flag.
  logic [11:0] q[$];
  logic        m_ovf;

  shift_cmd_fifo #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In_d      (In_d),
    .n_d       (n_d),
    .Lr_d      (Lr_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .In        (In),
    .n         (n),
    .Lr        (Lr),
    .count     (count),
    .overflow  (overflow)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(q.size() != 4));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    if (q.size() != 0) begin
      chk({tag, ".head"}, 32'({In, n, Lr}), 32'(q[0]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".in_ready"},  32'(in_ready),  32'(1));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, ".In"},        32'(In),        32'(0));
    chk({tag, ".n"},         32'(n),         32'(0));
    chk({tag, ".Lr"},        32'(Lr),        32'(0));
    chk({tag, ".count"},     32'(count),     32'(0));
    chk({tag, ".overflow"},  32'(overflow),  32'(0));
  endtask

  // One clock of traffic: apply inputs, predict from the pre-edge occupancy,
  // then compare shortly after the edge.
  task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                       input logic [2:0] a, input logic l, input logic r);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    In_d      = d;
    n_d       = a;
    Lr_d      = l;
    out_ready = r;
    do_push = v && (q.size() < 4);
    do_pop  = r && (q.size() > 0);
    if (v && q.size() == 4) m_ovf = 1'b1;
    @(posedge clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back({d, a, l});
    #1;
    check_all(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ovf       = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    In_d        = '0;
    n_d         = '0;
    Lr_d        = 1'b0;

    // Reset state.
    #2;
    check_reset_values("reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("idle");

    // Single pass.
    cycle("single_push", 1'b1, 8'd128, 3'd4, 1'b1, 1'b0);
    cycle("single_pop",  1'b0, 8'd0,   3'd0, 1'b0, 1'b1);
    cycle("empty_pop",   1'b0, 8'd0,   3'd0, 1'b0, 1'b1);

    // Fill and overflow.
    cycle("fill0", 1'b1, 8'd0,   3'd0, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 8'd128, 3'd4, 1'b1, 1'b0);
    cycle("fill2", 1'b1, 8'd128, 3'd2, 1'b0, 1'b0);
    cycle("fill3", 1'b1, 8'd128, 3'd1, 1'b0, 1'b0);
    cycle("ovf",   1'b1, 8'd255, 3'd7, 1'b0, 1'b0);
    cycle("full_push_pop", 1'b1, 8'd77, 3'd3, 1'b1, 1'b1);

    // Drain, then push/pop across the pointer wrap.
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'd0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle("wrap_push", 1'b1, 8'(8'h10 + i), 3'(i), 1'(i), 1'b0);
      cycle("wrap_pop",  1'b0, 8'd0, 3'd0, 1'b0, 1'b1);
    end

    // Simultaneous push and pop at count = 2.
    cycle("sim_a",  1'b1, 8'hA1, 3'd1, 1'b1, 1'b0);
    cycle("sim_b",  1'b1, 8'hB2, 3'd2, 1'b0, 1'b0);
    cycle("sim_pp", 1'b1, 8'hC3, 3'd3, 1'b1, 1'b1);
    chk("sim.head_is_second", 32'({In, n, Lr}), 32'({8'hB2, 3'd2, 1'b0}));

    // Reset mid-operation: asserted between edges, outputs clear at once.
    cycle("pre_rst", 1'b0, 8'd0, 3'd0, 1'b0, 1'b0);
    if (q.size() < 3) cycle("to3", 1'b1, 8'h5A, 3'd5, 1'b0, 1'b0);
    chk("pre_rst.count3", 32'(count), 32'(3));
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_ovf    = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cycle("post_rst_push", 1'b1, 8'd255, 3'd7, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_cmd_fifo.md
SHIFT_CMD_FIFO -- requirements
Module: shift_cmd_fifo

Upstream command buffer for the 8-bit barrel shifter. Holds {data, amount, direction} commands and presents the head entry to the shifter inputs with a valid/ready handshake.

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of command entries; the value is fixed at 4 for this release.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: producer offers a command.
REQ-005 SHALL have port in_ready, output, 1 bit: the FIFO can accept a command.
REQ-006 SHALL have port In_d, input, 8 bits: data word to be shifted.
REQ-007 SHALL have port n_d, input, 3 bits: shift amount, 0-7.
REQ-008 SHALL have port Lr_d, input, 1 bit: direction, 1 = left, 0 = right.
REQ-009 SHALL have port out_valid, output, 1 bit: the head command is present.
REQ-010 SHALL have port out_ready, input, 1 bit: the shifter stage consumes the head.
REQ-011 SHALL have port In, output, 8 bits: head data, driving the shifter In.
REQ-012 SHALL have port n, output, 3 bits: head amount, driving the shifter n.
REQ-013 SHALL have port Lr, output, 1 bit: head direction, driving the shifter Lr.
REQ-014 SHALL have port count, output, 3 bits: number of stored entries, 0-4.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set by a push attempted while full.

Function
REQ-016 SHALL perform a push when in_valid=1 and in_ready=1 at a rising edge, writing {In_d, n_d, Lr_d} at the write pointer.
REQ-017 SHALL perform a pop when out_valid=1 and out_ready=1 at a rising edge, advancing the read pointer.
REQ-018 SHALL drive in_ready = (count != 4), so a push is refused when full even if a pop occurs in the same cycle.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL present In/n/Lr as the entry at the read pointer (show-ahead), combinationally from registered storage.
REQ-021 SHALL make a command pushed at edge k visible on out_valid/In/n/Lr immediately after edge k (latency 1 edge, no bubble).
REQ-022 SHALL, on a simultaneous push and pop with 0 < count < 4, leave count unchanged and update both pointers.
REQ-023 SHALL ignore out_ready when count = 0; pointers and count stay unchanged.
REQ-024 SHALL use 2-bit pointers that wrap modulo 4 (3 -> 0) with no lost or duplicated entry.
REQ-025 SHALL increment count on a push only, decrement it on a pop only, and never let it exceed 4 or go below 0.
REQ-026 SHALL set overflow at the edge where in_valid=1 and count=4, and hold it until reset; the stored data is unchanged.
REQ-027 SHALL keep the head outputs stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk, clear the pointers, count, overflow and all storage entries.
REQ-029 SHALL hold these values during reset: in_ready=1, out_valid=0, In=0, n=0, Lr=0, count=0, overflow=0.
REQ-030 SHALL abandon all stored and in-flight commands when reset is asserted mid-operation; the first command after release is accepted normally.

Verification
REQ-031 Single pass: push {128,4,1} with out_ready=0 -> next cycle out_valid=1, In=128, n=4, Lr=1, count=1; assert out_ready -> count=0, out_valid=0.
REQ-032 Fill and overflow: push {0,0,0}, {128,4,1}, {128,2,0}, {128,1,0} -> count=4, in_ready=0; push {255,7,0} -> overflow=1, count=4, head still {0,0,0}.
REQ-033 Order and wrap: drain the 4 entries, then push and pop 6 more -> the outputs appear in push order across the pointer wrap 3 -> 0.
REQ-034 Simultaneous: at count=2, push and pop in one cycle -> count stays 2, head advances to the second entry.
REQ-035 Reset mid-operation: count=3, assert rst_n=0 between clock edges -> outputs clear immediately; after release, push {255,7,0} -> head = {255,7,0}.
